// File: rtl/regb_fifo_pkg.sv
// regb_fifo_pkg: shared definitions for the register-based shift FIFO.
//   - SEL_* : per-stage load-select encoding driven by the top-level decode
//   - cnt_w : width of a counter able to hold 0..depth
package regb_fifo_pkg;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_NEXT  = 2'b01;
  localparam logic [1:0] SEL_INPUT = 2'b10;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/regb_fifo_stage.sv
// regb_fifo_stage: one FIFO stage register (data + valid).
// Ports:
//   clk, res_n          clock / async active-low reset
//   i_sel               SEL_HOLD / SEL_NEXT / SEL_INPUT
//   i_next_data/_vld    contents of the stage behind this one
//   i_din               write data from the producer
//   o_data/o_vld        stage contents
module regb_fifo_stage
  import regb_fifo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic [1:0]       i_sel,
  input  logic [WIDTH-1:0] i_next_data,
  input  logic             i_next_vld,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_data,
  output logic             o_vld
);

  logic [WIDTH-1:0] r_data;
  logic             r_vld;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_data <= '0;
      r_vld  <= 1'b0;
    end else begin
      case (i_sel)
        SEL_NEXT: begin
          r_data <= i_next_data;
          r_vld  <= i_next_vld;
        end
        SEL_INPUT: begin
          r_data <= i_din;
          r_vld  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_data = r_data;
  assign o_vld  = r_vld;

endmodule

// File: rtl/regb_shift_fifo.sv
// regb_shift_fifo: DEPTH-stage register shift FIFO; stage 0 is the head.
// Ports:
//   clk, res_n                 clock / async active-low reset
//   shift_in, din              write strobe + data
//   shift_out                  read strobe (pops dout)
//   dout, empty_n, full_n      head data and availability flags
//   count                      number of valid words
//   almost_full, almost_empty  threshold flags (REGB_FIFO_ALMOST_EN)
//   overflow, underflow        sticky error flags, cleared by reset only
// Build option: define REGB_FIFO_ALMOST_EN to decode the almost flags
// from count; otherwise both are tied low.
module regb_shift_fifo
  import regb_fifo_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                    clk,
  input  logic                    res_n,
  input  logic                    shift_in,
  input  logic [WIDTH-1:0]        din,
  input  logic                    shift_out,
  output logic [WIDTH-1:0]        dout,
  output logic                    empty_n,
  output logic                    full_n,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int CW = cnt_w(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] w_data;
  logic [DEPTH-1:0]            w_vld;
  logic [DEPTH-1:0][1:0]       w_sel;
  logic [CW-1:0]               r_count;
  logic [CW-1:0]               w_wr_idx;
  logic                        w_wr, w_rd;
  logic                        r_ovf, r_unf;

  // A pop frees a slot this edge, so a write at full proceeds with a read.
  assign w_wr = shift_in & (full_n | shift_out);
  assign w_rd = shift_out & empty_n;
  // With a simultaneous pop everything moves down one, so the write lands
  // one slot lower than the current tail.
  assign w_wr_idx = w_rd ? r_count - 1'b1 : r_count;

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_wr && (w_wr_idx == CW'(i))) w_sel[i] = SEL_INPUT;
      else if (w_rd)                    w_sel[i] = SEL_NEXT;
      else                              w_sel[i] = SEL_HOLD;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] w_nd;
    logic             w_nv;
    if (i == DEPTH - 1) begin : g_tail
      // Tail shifts in an empty slot on a pop.
      assign w_nd = '0;
      assign w_nv = 1'b0;
    end else begin : g_body
      assign w_nd = w_data[i+1];
      assign w_nv = w_vld[i+1];
    end
    regb_fifo_stage #(.WIDTH(WIDTH)) u_stage (
      .clk         (clk),
      .res_n       (res_n),
      .i_sel       (w_sel[i]),
      .i_next_data (w_nd),
      .i_next_vld  (w_nv),
      .i_din       (din),
      .o_data      (w_data[i]),
      .o_vld       (w_vld[i])
    );
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
      if (shift_in & ~full_n & ~shift_out) r_ovf <= 1'b1;
      if (shift_out & ~empty_n)            r_unf <= 1'b1;
    end
  end

  assign dout      = w_data[0];
  assign count     = r_count;
  assign empty_n   = (r_count != '0);
  assign full_n    = (r_count != CW'(DEPTH));
  assign overflow  = r_ovf;
  assign underflow = r_unf;

`ifdef REGB_FIFO_ALMOST_EN
  assign almost_full  = (r_count >= CW'(AF_LEVEL));
  assign almost_empty = (r_count <= CW'(AE_LEVEL));
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

endmodule

// File: doc/regb_shift_fifo.md
# regb_shift_fifo

Parametrised register-based shift FIFO. It generalises the single FIFO cell into a complete DEPTH-stage chain with a registered output stage, fill count, sticky error flags and optional almost-full/almost-empty thresholds. It sits between a producer and a consumer that both use the codebase's shift_in/shift_out strobe handshake. Each stage is one instance of a generic stage cell.

## Interface
Parameters:
- WIDTH, 4: data width in bits, ≥1
- DEPTH, 4: number of stages, ≥2
- AF_LEVEL, DEPTH-1: almost_full asserts when count ≥ AF_LEVEL
- AE_LEVEL, 1: almost_empty asserts when count ≤ AE_LEVEL

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- res_n  in  1  asynchronous, active-low reset
- shift_in  in  1  write strobe; samples din this cycle
- din  in  WIDTH  write data
- shift_out  in  1  read strobe; pops the word currently on dout
- dout  out  WIDTH  head-of-queue data (stage 0 register)
- empty_n  out  1  1 = dout holds valid data
- full_n  out  1  1 = at least one free stage
- count  out  $clog2(DEPTH+1)  number of valid words
- almost_full  out  1  count ≥ AF_LEVEL (see Configuration)
- almost_empty  out  1  count ≤ AE_LEVEL (see Configuration)
- overflow  out  1  sticky: write dropped
- underflow  out  1  sticky: read on empty

## Operation
- Stages 0..DEPTH-1; stage 0 drives dout. Valid bits form a thermometer code: stages 0..count-1 valid, rest invalid.
- Accepted write: shift_in & (full_n | shift_out). Accepted read: shift_out & empty_n.
- Per-stage select, one-hot per cycle:
  - HOLD when neither event applies.
  - NEXT: load stage i+1 data when a read is accepted and i < DEPTH-1.
  - INPUT: load din at index count (write only) or count-1 (write + read).
- Stage DEPTH-1 loads zero-valid on read without write.
- count: +1 on write only; −1 on read only; unchanged on both or neither.
- Full (count = DEPTH):
  - write + read: both accepted; din lands in stage DEPTH-1.
  - write alone: dropped; overflow set; contents unchanged.
- Empty (count = 0):
  - read alone: ignored; underflow set.
  - write + read: write accepted into stage 0; read ignored; underflow set.
- overflow/underflow clear only on reset.
- Flags are combinational decodes of registered count: empty_n = (count≠0), full_n = (count≠DEPTH).
- Invalid stage data is don't-care; implementation zeroes it on reset only.

## Timing
- Reset (async assert, sync release by the environment): all stage data 0, all valid 0, count 0. Outputs: dout 0, empty_n 0, full_n 1, almost_full 0, almost_empty 1 (if compiled in), overflow 0, underflow 0.
- Reset asserted mid-operation discards all contents immediately; no partial pop.
- Write latency: din written in cycle t into an empty FIFO appears on dout with empty_n=1 after edge t+1.
- Read: dout advances to the next word on the edge that accepts shift_out.
- Flags and count reflect the post-edge state in the same cycle as dout.
- Throughput: one write and one read per cycle, sustained, at any fill level including full.

## Configuration
- REGB_FIFO_ALMOST_EN defined: almost_full/almost_empty decoded from count against AF_LEVEL/AE_LEVEL.
- Not defined: comparators are absent; almost_full is tied 0 and almost_empty is tied 0. AF_LEVEL/AE_LEVEL are ignored. All other behaviour is identical.

## Structure
- Package regb_fifo_pkg contains:
  - Stage-select encoding constants SEL_HOLD=2'b00, SEL_NEXT=2'b01, SEL_INPUT=2'b10.
  - Count-width helper function.
- Sub-module regb_fifo_stage contains one stage register: data + valid, 2-bit select input, next-stage and input data ports, async reset. It is instantiated DEPTH times via generate.
- Top level contains the select decode, count register, flags and sticky errors.

## Test plan
- Reset, then write 0xA1,0xB2,0xC3 (WIDTH=8, DEPTH=4) on consecutive cycles → dout=0xA1 one cycle after the first write; count=3; empty_n=1; full_n=1.
- Fill to 4, then write 0xFF alone → overflow=1; count stays 4; then 4 reads return the original order exactly.
- At full, simultaneous write 0x55 + read → count stays 4; the popped word is the head; 0x55 emerges last.
- On empty, read → underflow=1; count 0. On empty, simultaneous write 0x77 + read → count=1; dout=0x77; underflow=1.
- With REGB_FIFO_ALMOST_EN, AF_LEVEL=3, AE_LEVEL=1: almost_empty=1 at counts 0–1; almost_full=1 at counts 3–4. Without the macro, both flags stay 0.
- Drop res_n at count=3 mid-burst → all outputs take their reset values immediately; first write after release appears on dout after one edge.
